mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single memory device between two requesters: port D (data, stage_mem) and
//   port I (instruction fetch). Each requester port uses the memdev protocol: hold opt/addr/wdata,
//   see busy rise, then fall; read data is valid when busy falls.
//   The arbiter serialises accesses, drives the device port and returns read data to the owner.
//   It sits between the pipeline stages and the memory/bus controller.
// PARAMETERS
//   STARVE_LIMIT  4  consecutive D grants while I pending before I gets forced priority (>=1)
// PORTS
//   clk            in   1               system clock; all state changes on posedge
//   rst            in   1               reset, asynchronous, active-low
//   d_addr         in   32              port D address
//   d_data_out     in   32              port D write data
//   d_opt          in   MEM_OPT_WIDTH   port D operation (`MEM_OPT_NONE = no request)
//   d_data_in      out  32              port D read data
//   d_busy         out  1               port D busy
//   i_addr         in   32              port I address
//   i_data_out     in   32              port I write data
//   i_opt          in   MEM_OPT_WIDTH   port I operation
//   i_data_in      out  32              port I read data
//   i_busy         out  1               port I busy
//   dev_addr       out  32              device address
//   dev_data_out   out  32              device write data
//   dev_opt        out  MEM_OPT_WIDTH   device operation
//   dev_data_in    in   32              device read data
//   dev_busy       in   1               device busy
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; dev_opt=`MEM_OPT_NONE; dev_addr, dev_data_out,
//     d/i_data_in = 0; d/i_busy = 0; served_d = served_i = 0; starve cnt = 0.
//   New request on a port: opt != NONE and served_x == 0.
//     served_x sets on completion of that port's access.
//     served_x clears when opt == NONE or any of opt/addr/data_out differs from the latched copy.
//     A held request is therefore never re-issued.
//   x_busy is registered. It goes 1 on the first edge a new request is seen, whether granted or
//     waiting, and stays 1 until that access completes.
//   FSM:
//   - IDLE: if any new request, grant it.
//     Register dev_addr/dev_data_out/dev_opt from the winner and latch its copy.
//     Go to WAIT_BUSY.
//   - WAIT_BUSY: hold device outputs. If dev_busy=1, go to WAIT_UNBUSY.
//   - WAIT_UNBUSY: on dev_busy=0:
//     owner x_data_in <= dev_data_in (also for writes); owner x_busy <= 0; served_x <= 1;
//     dev_opt <= NONE; go to RELEASE.
//   - RELEASE: one cycle with dev_opt=NONE so the device sees a fresh request. Go to IDLE.
//     No grant is made in RELEASE.
//   Priority: D wins simultaneous requests unless starve cnt == STARVE_LIMIT, then I wins.
//     cnt increments on each D grant while I has a new request pending (saturates).
//     cnt clears on any I grant.
//   Latency, idle arbiter: grant edge = first edge the request is seen. dev_opt is visible the
//     cycle after. Requester busy falls on the edge after dev_busy falls.
//   Requester opt changed mid-access: the in-flight device access is unaffected and completes
//     with the latched values; the new request is served afterwards.
//   Requester opt dropped to NONE mid-access: the access still completes; busy falls normally.
//   Reset asserted mid-access: immediate return to the reset values; the device access is
//     abandoned.
//   Non-owner data_in holds its previous value.
// TESTING
//   D read only, addr=0x100; dev raises busy 2 cycles, dev_data_in=0xDEADBEEF ->
//     dev_opt read at 0x100; d_busy 1 then 0; d_data_in=0xDEADBEEF; one RELEASE cycle.
//   D and I new requests on the same edge (D write 0x200 data 0x55, I read 0x0) ->
//     D served first, then I after RELEASE; i_busy stays high throughout.
//   D held continuously changing addr every access, I pending, STARVE_LIMIT=4 ->
//     I granted after exactly 4 D grants; cnt resets.
//   D holds the same request after completion for 10 cycles ->
//     no second device access; d_busy stays 0.
//   rst=0 asynchronously while in WAIT_UNBUSY ->
//     outputs at reset values before the next edge; after release, a fresh I request is served
//     normally.
//   I read completes with dev_data_in=0x12345678 ->
//     i_data_in=0x12345678; d_data_in unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter placing a data port (D) and an instruction-fetch port (I) in front of one memdev device.
// Accesses are serialised, D has priority with bounded I starvation, and a held request is served only once.
`timescale 1ns/1ps
`ifndef MEM_OPT_WIDTH
`define MEM_OPT_WIDTH 3
`endif
`ifndef MEM_OPT_NONE
`define MEM_OPT_NONE 3'd0
`endif

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               d_addr,
    input  logic [31:0]               d_data_out,
    input  logic [`MEM_OPT_WIDTH-1:0] d_opt,
    output logic [31:0]               d_data_in,
    output logic                      d_busy,
    input  logic [31:0]               i_addr,
    input  logic [31:0]               i_data_out,
    input  logic [`MEM_OPT_WIDTH-1:0] i_opt,
    output logic [31:0]               i_data_in,
    output logic                      i_busy,
    output logic [31:0]               dev_addr,
    output logic [31:0]               dev_data_out,
    output logic [`MEM_OPT_WIDTH-1:0] dev_opt,
    input  logic [31:0]               dev_data_in,
    input  logic                      dev_busy
);
    localparam int OW = `MEM_OPT_WIDTH;
    localparam logic [OW-1:0] OPT_NONE = `MEM_OPT_NONE;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY   = 2'd1;
    localparam logic [1:0] ST_WAIT_UNBUSY = 2'd2;
    localparam logic [1:0] ST_RELEASE     = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          owner_i_q, owner_i_d;
    logic [31:0]   dev_addr_q, dev_addr_d;
    logic [31:0]   dev_data_out_q, dev_data_out_d;
    logic [OW-1:0] dev_opt_q, dev_opt_d;
    logic [31:0]   d_data_in_q, d_data_in_d;
    logic [31:0]   i_data_in_q, i_data_in_d;
    logic          d_busy_q, d_busy_d;
    logic          i_busy_q, i_busy_d;
    logic          served_d_q, served_d_d;
    logic          served_i_q, served_i_d;
    logic [OW-1:0] d_lat_opt_q, d_lat_opt_d;
    logic [31:0]   d_lat_addr_q, d_lat_addr_d;
    logic [31:0]   d_lat_data_q, d_lat_data_d;
    logic [OW-1:0] i_lat_opt_q, i_lat_opt_d;
    logic [31:0]   i_lat_addr_q, i_lat_addr_d;
    logic [31:0]   i_lat_data_q, i_lat_data_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    logic d_same, i_same, d_new, i_new, grant_i, complete, in_flight;

    // A request counts as already served only while it is identical to the copy latched at its grant.
    assign d_same  = (d_opt == d_lat_opt_q) && (d_addr == d_lat_addr_q) && (d_data_out == d_lat_data_q);
    assign i_same  = (i_opt == i_lat_opt_q) && (i_addr == i_lat_addr_q) && (i_data_out == i_lat_data_q);
    assign d_new   = (d_opt != OPT_NONE) && !(served_d_q && d_same);
    assign i_new   = (i_opt != OPT_NONE) && !(served_i_q && i_same);
    assign grant_i = i_new && (!d_new || (starve_cnt_q == CNT_MAX));

    always_comb begin
        state_d        = state_q;
        owner_i_d      = owner_i_q;
        dev_addr_d     = dev_addr_q;
        dev_data_out_d = dev_data_out_q;
        dev_opt_d      = dev_opt_q;
        d_data_in_d    = d_data_in_q;
        i_data_in_d    = i_data_in_q;
        d_lat_opt_d    = d_lat_opt_q;
        d_lat_addr_d   = d_lat_addr_q;
        d_lat_data_d   = d_lat_data_q;
        i_lat_opt_d    = i_lat_opt_q;
        i_lat_addr_d   = i_lat_addr_q;
        i_lat_data_d   = i_lat_data_q;
        starve_cnt_d   = starve_cnt_q;
        complete       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_new || i_new) begin
                    state_d   = ST_WAIT_BUSY;
                    owner_i_d = grant_i;
                    if (grant_i) begin
                        dev_addr_d     = i_addr;
                        dev_data_out_d = i_data_out;
                        dev_opt_d      = i_opt;
                        i_lat_opt_d    = i_opt;
                        i_lat_addr_d   = i_addr;
                        i_lat_data_d   = i_data_out;
                        starve_cnt_d   = '0;
                    end else begin
                        dev_addr_d     = d_addr;
                        dev_data_out_d = d_data_out;
                        dev_opt_d      = d_opt;
                        d_lat_opt_d    = d_opt;
                        d_lat_addr_d   = d_addr;
                        d_lat_data_d   = d_data_out;
                        if (i_new && (starve_cnt_q != CNT_MAX)) begin
                            starve_cnt_d = starve_cnt_q + CW'(1);
                        end
                    end
                end
            end
            ST_WAIT_BUSY: begin
                if (dev_busy) begin
                    state_d = ST_WAIT_UNBUSY;
                end
            end
            ST_WAIT_UNBUSY: begin
                if (!dev_busy) begin
                    complete  = 1'b1;
                    dev_opt_d = OPT_NONE;
                    state_d   = ST_RELEASE;
                    if (owner_i_q) begin
                        i_data_in_d = dev_data_in;
                    end else begin
                        d_data_in_d = dev_data_in;
                    end
                end
            end
            ST_RELEASE: begin
                // Device must see opt=NONE for a cycle before the next grant.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Busy follows a pending request, is pinned high for the owner in flight and drops on completion.
    always_comb begin
        in_flight  = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_UNBUSY);
        d_busy_d   = d_new;
        i_busy_d   = i_new;
        served_d_d = served_d_q && d_same && (d_opt != OPT_NONE);
        served_i_d = served_i_q && i_same && (i_opt != OPT_NONE);
        if (in_flight && !owner_i_q) begin
            d_busy_d = 1'b1;
        end
        if (in_flight && owner_i_q) begin
            i_busy_d = 1'b1;
        end
        if (complete && !owner_i_q) begin
            d_busy_d   = 1'b0;
            served_d_d = 1'b1;
        end
        if (complete && owner_i_q) begin
            i_busy_d   = 1'b0;
            served_i_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            owner_i_q      <= 1'b0;
            dev_addr_q     <= '0;
            dev_data_out_q <= '0;
            dev_opt_q      <= OPT_NONE;
            d_data_in_q    <= '0;
            i_data_in_q    <= '0;
            d_busy_q       <= 1'b0;
            i_busy_q       <= 1'b0;
            served_d_q     <= 1'b0;
            served_i_q     <= 1'b0;
            d_lat_opt_q    <= OPT_NONE;
            d_lat_addr_q   <= '0;
            d_lat_data_q   <= '0;
            i_lat_opt_q    <= OPT_NONE;
            i_lat_addr_q   <= '0;
            i_lat_data_q   <= '0;
            starve_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            owner_i_q      <= owner_i_d;
            dev_addr_q     <= dev_addr_d;
            dev_data_out_q <= dev_data_out_d;
            dev_opt_q      <= dev_opt_d;
            d_data_in_q    <= d_data_in_d;
            i_data_in_q    <= i_data_in_d;
            d_busy_q       <= d_busy_d;
            i_busy_q       <= i_busy_d;
            served_d_q     <= served_d_d;
            served_i_q     <= served_i_d;
            d_lat_opt_q    <= d_lat_opt_d;
            d_lat_addr_q   <= d_lat_addr_d;
            d_lat_data_q   <= d_lat_data_d;
            i_lat_opt_q    <= i_lat_opt_d;
            i_lat_addr_q   <= i_lat_addr_d;
            i_lat_data_q   <= i_lat_data_d;
            starve_cnt_q   <= starve_cnt_d;
        end
    end

    assign dev_addr     = dev_addr_q;
    assign dev_data_out = dev_data_out_q;
    assign dev_opt      = dev_opt_q;
    assign d_data_in    = d_data_in_q;
    assign i_data_in    = i_data_in_q;
    assign d_busy       = d_busy_q;
    assign i_busy       = i_busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized two-port traffic checked against per-port memory models and access logs.
`timescale 1ns/1ps
`ifndef MEM_OPT_WIDTH
`define MEM_OPT_WIDTH 3
`endif
`ifndef MEM_OPT_NONE
`define MEM_OPT_NONE 3'd0
`endif

module tb_mem_arbiter;
    localparam int W = `MEM_OPT_WIDTH;
    localparam logic [W-1:0] OP_NONE = `MEM_OPT_NONE;
    localparam logic [W-1:0] OP_RD   = W'(1);
    localparam logic [W-1:0] OP_WR   = W'(2);
    localparam int LIMIT = 4;

    typedef struct {
        logic [W-1:0] opt;
        logic [31:0]  addr;
        logic [31:0]  data;
    } acc_t;

    typedef struct {
        bit           port;
        logic [W-1:0] op;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        int           blen;
        logic [31:0]  resp;
        int           exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] d_addr = '0, d_data_out = '0, i_addr = '0, i_data_out = '0;
    logic [W-1:0] d_opt = OP_NONE, i_opt = OP_NONE;
    logic [31:0] d_data_in, i_data_in, dev_addr, dev_data_out;
    logic        d_busy, i_busy;
    logic [W-1:0] dev_opt;
    logic [31:0] dev_data_in = '0;
    logic        dev_busy = 1'b0;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .d_addr(d_addr), .d_data_out(d_data_out), .d_opt(d_opt),
        .d_data_in(d_data_in), .d_busy(d_busy),
        .i_addr(i_addr), .i_data_out(i_data_out), .i_opt(i_opt),
        .i_data_in(i_data_in), .i_busy(i_busy),
        .dev_addr(dev_addr), .dev_data_out(dev_data_out), .dev_opt(dev_opt),
        .dev_data_in(dev_data_in), .dev_busy(dev_busy)
    );

    always #5 clk = ~clk;

    // Device model: busy for dv_busy_len cycles, then returns data; logs each access by port.
    int   dv_state = 0;
    int   dv_left = 0;
    int   dv_busy_len = 2;
    bit   dv_override = 1'b0;
    bit   dv_rand = 1'b0;
    logic [31:0] dv_resp = '0;
    logic [31:0] dv_mem [logic [31:0]];
    acc_t dv_acc;
    acc_t log_d[$];
    acc_t log_i[$];
    int   order[$];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            dv_state = 0;
            dev_busy = 1'b0;
        end else begin
            case (dv_state)
                0: if (dev_opt != OP_NONE) begin
                    dv_acc = '{dev_opt, dev_addr, dev_data_out};
                    if (dev_opt == d_opt && dev_addr == d_addr && dev_data_out == d_data_out) begin
                        log_d.push_back(dv_acc);
                        order.push_back(0);
                    end else begin
                        log_i.push_back(dv_acc);
                        order.push_back(1);
                    end
                    dev_busy = 1'b1;
                    dv_left  = dv_rand ? int'($urandom_range(1, 4)) : dv_busy_len;
                    dv_state = 1;
                end
                1: begin
                    dv_left = dv_left - 1;
                    if (dv_left <= 0) begin
                        dev_busy = 1'b0;
                        if (dv_override) dev_data_in = dv_resp;
                        else if (dv_acc.opt == OP_WR) dev_data_in = ~dv_acc.data;
                        else if (dv_mem.exists(dv_acc.addr)) dev_data_in = dv_mem[dv_acc.addr];
                        else dev_data_in = dflt(dv_acc.addr);
                        if (dv_acc.opt == OP_WR) dv_mem[dv_acc.addr] = dv_acc.data;
                        dv_state = 2;
                    end
                end
                default: if (dev_opt == OP_NONE) dv_state = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit p, input logic [W-1:0] op, input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            i_opt = op; i_addr = a; i_data_out = wd;
        end else begin
            d_opt = op; d_addr = a; d_data_out = wd;
        end
    endtask

    function automatic logic get_busy(input bit p);
        return p ? i_busy : d_busy;
    endfunction

    function automatic logic [31:0] get_din(input bit p);
        return p ? i_data_in : d_data_in;
    endfunction

    // Issue a request at the current negedge and wait (bounded) for busy to rise and fall.
    task automatic do_access(input bit p, input logic [W-1:0] op, input logic [31:0] a,
                             input logic [31:0] wd, output int lat, output logic [W-1:0] c_opt,
                             output logic [31:0] c_addr, output logic [31:0] c_data, output bit ok);
        bit seen;
        seen = 1'b0; ok = 1'b0; lat = 0;
        c_opt = OP_NONE; c_addr = '0; c_data = '0;
        set_req(p, op, a, wd);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                c_opt = dev_opt; c_addr = dev_addr; c_data = dev_data_out;
            end
            if (!seen) begin
                if (get_busy(p)) seen = 1'b1;
            end else if (!get_busy(p)) begin
                ok = 1'b1;
                break;
            end
        end
        chk(p ? "i_access_done" : "d_access_done", 32'(ok), 32'd1);
    endtask

    task automatic chk_log(input bit p, input logic [W-1:0] op, input logic [31:0] a, input logic [31:0] wd);
        acc_t e;
        int   sz;
        sz = p ? log_i.size() : log_d.size();
        chk("log_present", 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            if (p) e = log_i.pop_front();
            else   e = log_d.pop_front();
            chk("log_opt", 32'(e.opt), 32'(op));
            chk("log_addr", e.addr, a);
            chk("log_data", e.data, wd);
        end
    endtask

    task automatic rand_port(input bit p, input int n);
        logic [31:0] refm [logic [31:0]];
        logic [W-1:0] op, c_o;
        logic [31:0]  a, wd, rnd, expv, c_a, c_d;
        int lat, gap, oi0, idx, dcount;
        bit ok;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                set_req(p, OP_NONE, '0, '0);
                repeat (gap) @(negedge clk);
            end
            op  = ($urandom_range(0, 1) == 1) ? OP_WR : OP_RD;
            a   = (p ? 32'h3000 : 32'h2000) + 32'($urandom_range(0, 7)) * 32'd4;
            rnd = $urandom;
            wd  = {8'(k), rnd[23:0]};
            if (op == OP_WR) expv = ~wd;
            else if (refm.exists(a)) expv = refm[a];
            else expv = dflt(a);
            oi0 = order.size();
            do_access(p, op, a, wd, lat, c_o, c_a, c_d, ok);
            $display("rand port=%0d op=%0d addr=%h data_in=%h exp=%h", p, op, a, get_din(p), expv);
            chk(p ? "rand_i_data" : "rand_d_data", get_din(p), expv);
            chk_log(p, op, a, wd);
            if (op == OP_WR) refm[a] = wd;
            if (p) begin
                idx = -1;
                for (int j = order.size() - 1; j >= 0; j--) begin
                    if (order[j] == 1) begin idx = j; break; end
                end
                dcount = 0;
                for (int j = oi0; j < idx; j++) if (order[j] == 0) dcount++;
                chk("i_starve_bound", 32'(dcount <= LIMIT + 1), 32'd1);
            end
        end
        set_req(p, OP_NONE, '0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [6];
        logic [31:0] exp_din [2];
        logic [W-1:0] c_o;
        logic [31:0]  c_a, c_d;
        int lat, d_idx, i_idx, n0;
        bit ok;
        int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        vt[0] = '{1'b0, OP_RD, 32'h0000_0100, 32'h0,        2, 32'hDEADBEEF, 4};
        vt[1] = '{1'b1, OP_RD, 32'h0000_0000, 32'h0,        1, 32'h12345678, 3};
        vt[2] = '{1'b0, OP_WR, 32'h0000_0200, 32'h55,       3, 32'hCAFEF00D, 5};
        vt[3] = '{1'b1, OP_WR, 32'h0000_0040, 32'h1234,     4, 32'h0BADF00D, 6};
        vt[4] = '{1'b1, OP_RD, 32'h0000_0044, 32'h0,        2, 32'h12345678, 4};
        vt[5] = '{1'b0, OP_RD, 32'hFFFF_FFFC, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 3};

        // Reset state
        #2 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_dev_opt", 32'(dev_opt), 32'(OP_NONE));
        chk("rst_dev_addr", dev_addr, 32'h0);
        chk("rst_dev_data_out", dev_data_out, 32'h0);
        chk("rst_d_data_in", d_data_in, 32'h0);
        chk("rst_i_data_in", i_data_in, 32'h0);
        chk("rst_busy", {30'd0, d_busy, i_busy}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single accesses on an idle arbiter
        exp_din[0] = '0; exp_din[1] = '0;
        dv_override = 1'b1;
        for (int v = 0; v < 6; v++) begin
            dv_busy_len = vt[v].blen;
            dv_resp     = vt[v].resp;
            do_access(vt[v].port, vt[v].op, vt[v].addr, vt[v].wdata, lat, c_o, c_a, c_d, ok);
            exp_din[vt[v].port] = vt[v].resp;
            $display("vec %0d port=%0d op=%0d addr=%h lat=%0d d_in=%h i_in=%h", v, vt[v].port, vt[v].op,
                     vt[v].addr, lat, d_data_in, i_data_in);
            chk("vec_dev_opt", 32'(c_o), 32'(vt[v].op));
            chk("vec_dev_addr", c_a, vt[v].addr);
            chk("vec_dev_wdata", c_d, vt[v].wdata);
            chk("vec_latency", 32'(lat), 32'(vt[v].exp_lat));
            chk("vec_d_data_in", d_data_in, exp_din[0]);
            chk("vec_i_data_in", i_data_in, exp_din[1]);
            chk("vec_release_opt", 32'(dev_opt), 32'(OP_NONE));
            set_req(vt[v].port, OP_NONE, '0, '0);
            repeat (2) @(negedge clk);
        end

        // Simultaneous D write and I read: D first, I after RELEASE, i_busy high throughout
        order.delete(); log_d.delete(); log_i.delete();
        dv_busy_len = 2; dv_resp = 32'hA1B2C3D4;
        set_req(0, OP_WR, 32'h200, 32'h55);
        set_req(1, OP_RD, 32'h0, 32'h0);
        d_idx = -1; i_idx = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (d_idx < 0 && !d_busy) d_idx = k;
            if (!i_busy) begin i_idx = k; break; end
        end
        $display("simul d_done=%0d i_done=%0d d_in=%h i_in=%h", d_idx, i_idx, d_data_in, i_data_in);
        chk("simul_d_done", 32'(d_idx), 32'd3);
        chk("simul_i_done", 32'(i_idx), 32'd8);
        chk("simul_i_data", i_data_in, 32'hA1B2C3D4);
        chk("simul_order_n", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("simul_first", 32'(order[0]), 32'd0);
            chk("simul_second", 32'(order[1]), 32'd1);
        end
        chk_log(0, OP_WR, 32'h200, 32'h55);
        chk_log(1, OP_RD, 32'h0, 32'h0);
        set_req(0, OP_NONE, '0, '0);
        set_req(1, OP_NONE, '0, '0);
        repeat (2) @(negedge clk);

        // Starvation: D continuously re-requesting, I pending
        order.delete(); log_d.delete(); log_i.delete();
        dv_busy_len = 1;
        fork
            begin
                logic [W-1:0] f_o; logic [31:0] f_a, f_d; int f_l; bit f_ok;
                for (int k = 0; k < 8; k++)
                    do_access(0, OP_RD, 32'h300 + 32'(k) * 32'd4, 32'h0, f_l, f_o, f_a, f_d, f_ok);
            end
            begin
                logic [W-1:0] g_o; logic [31:0] g_a, g_d; int g_l; bit g_ok;
                do_access(1, OP_RD, 32'h1000, 32'h0, g_l, g_o, g_a, g_d, g_ok);
                do_access(1, OP_RD, 32'h1004, 32'h0, g_l, g_o, g_a, g_d, g_ok);
            end
        join
        $display("starve order size=%0d", order.size());
        chk("starve_order_n", 32'(order.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            chk("starve_order", (k < order.size()) ? 32'(order[k]) : 32'd99, 32'(exp_order[k]));
        end
        set_req(0, OP_NONE, '0, '0);
        set_req(1, OP_NONE, '0, '0);
        repeat (2) @(negedge clk);

        // Held request after completion is not re-issued
        dv_resp = 32'h0F0F0F0F;
        do_access(0, OP_RD, 32'h500, 32'h0, lat, c_o, c_a, c_d, ok);
        n0 = order.size();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_d_busy", 32'(d_busy), 32'd0);
        end
        $display("hold accesses before=%0d after=%0d", n0, order.size());
        chk("hold_no_reissue", 32'(order.size()), 32'(n0));
        set_req(0, OP_NONE, '0, '0);
        repeat (2) @(negedge clk);

        // Asynchronous reset while in WAIT_UNBUSY
        dv_busy_len = 6;
        set_req(0, OP_RD, 32'h600, 32'h0);
        repeat (3) @(negedge clk);
        chk("pre_rst_dev_busy", 32'(dev_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        $display("async rst dev_opt=%0d d_busy=%0d d_in=%h", dev_opt, d_busy, d_data_in);
        chk("arst_dev_opt", 32'(dev_opt), 32'(OP_NONE));
        chk("arst_dev_addr", dev_addr, 32'h0);
        chk("arst_dev_data_out", dev_data_out, 32'h0);
        chk("arst_d_data_in", d_data_in, 32'h0);
        chk("arst_i_data_in", i_data_in, 32'h0);
        chk("arst_busy", {30'd0, d_busy, i_busy}, 32'h0);
        set_req(0, OP_NONE, '0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        order.delete(); log_d.delete(); log_i.delete();
        @(negedge clk);
        dv_busy_len = 2; dv_resp = 32'h77778888;
        do_access(1, OP_RD, 32'h700, 32'h0, lat, c_o, c_a, c_d, ok);
        $display("post-reset I read lat=%0d i_in=%h", lat, i_data_in);
        chk("post_rst_lat", 32'(lat), 32'd4);
        chk("post_rst_i_data", i_data_in, 32'h77778888);
        chk("post_rst_d_data", d_data_in, 32'h0);
        chk_log(1, OP_RD, 32'h700, 32'h0);
        set_req(1, OP_NONE, '0, '0);
        repeat (2) @(negedge clk);

        // Randomized concurrent traffic
        order.delete(); log_d.delete(); log_i.delete();
        dv_override = 1'b0;
        dv_rand = 1'b1;
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        repeat (4) @(negedge clk);
        chk("rand_log_d_empty", 32'(log_d.size()), 32'd0);
        chk("rand_log_i_empty", 32'(log_i.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
